visca_zoom_tx: RTL and testbench

- Parametrised VISCA zoom command transmitter. It succeeds the fixed 8-entry zoom byte ROM.
- Accepts one zoom request at a time: stop, tele-variable, wide-variable or direct position.
- Builds the full VISCA packet from the camera address, speed and position fields.
- Streams the packet one byte per valid/ready handshake into the camera UART transmitter, then enforces an inter-command gap.

---
 rtl/visca_pkg.sv | 29 ++
 rtl/visca_zoom_bytesel.sv | 49 ++++
 rtl/visca_zoom_tx.sv | 122 ++++++++++++
 tb/tb_visca_zoom_tx.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/visca_pkg.sv
// rtl/visca_pkg.sv - VISCA zoom opcodes, packet byte constants and FSM states
package visca_pkg;

  typedef enum logic [1:0] {
    VISCA_OP_STOP   = 2'd0,
    VISCA_OP_TELE   = 2'd1,
    VISCA_OP_WIDE   = 2'd2,
    VISCA_OP_DIRECT = 2'd3
  } visca_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } visca_tx_state_e;

  localparam logic [7:0] VISCA_HDR_BASE    = 8'h80;
  localparam logic [7:0] VISCA_CAT_CMD     = 8'h01;
  localparam logic [7:0] VISCA_CAT_CAM     = 8'h04;
  localparam logic [7:0] VISCA_ZOOM        = 8'h07;
  localparam logic [7:0] VISCA_ZOOM_DIRECT = 8'h47;
  localparam logic [7:0] VISCA_TERM        = 8'hFF;
  localparam logic [3:0] VISCA_TELE_NIB    = 4'h2;
  localparam logic [3:0] VISCA_WIDE_NIB    = 4'h3;

  localparam int VISCA_LEN_ZOOM   = 6;
  localparam int VISCA_LEN_DIRECT = 9;

endpackage

// File: rtl/visca_zoom_bytesel.sv
// rtl/visca_zoom_bytesel.sv - combinational VISCA zoom packet byte lookup
module visca_zoom_bytesel
  import visca_pkg::*;
#(
  parameter int CAM_ADDR = 1
) (
  input  visca_op_e   op,
  input  logic [3:0]  index,
  input  logic [2:0]  speed,
  input  logic [15:0] pos,
  output logic [7:0]  data,
  output logic        last
);

  localparam logic [3:0] LAST_ZOOM   = 4'(VISCA_LEN_ZOOM - 1);
  localparam logic [3:0] LAST_DIRECT = 4'(VISCA_LEN_DIRECT - 1);

  logic direct;
  logic [7:0] zoom_arg;

  assign direct = (op == VISCA_OP_DIRECT);

  always_comb begin
    zoom_arg = 8'h00;
    case (op)
      VISCA_OP_TELE: zoom_arg = {VISCA_TELE_NIB, 1'b0, speed};
      VISCA_OP_WIDE: zoom_arg = {VISCA_WIDE_NIB, 1'b0, speed};
      default:       zoom_arg = 8'h00;
    endcase
  end

  always_comb begin
    data = 8'h00;
    last = direct ? (index == LAST_DIRECT) : (index == LAST_ZOOM);
    case (index)
      4'd0:    data = VISCA_HDR_BASE | 8'(CAM_ADDR);
      4'd1:    data = VISCA_CAT_CMD;
      4'd2:    data = VISCA_CAT_CAM;
      4'd3:    data = direct ? VISCA_ZOOM_DIRECT : VISCA_ZOOM;
      4'd4:    data = direct ? {4'h0, pos[15:12]} : zoom_arg;
      4'd5:    data = direct ? {4'h0, pos[11:8]} : VISCA_TERM;
      4'd6:    data = direct ? {4'h0, pos[7:4]} : 8'h00;
      4'd7:    data = direct ? {4'h0, pos[3:0]} : 8'h00;
      4'd8:    data = direct ? VISCA_TERM : 8'h00;
      default: data = 8'h00;
    endcase
  end

endmodule

// File: rtl/visca_zoom_tx.sv
// rtl/visca_zoom_tx.sv - VISCA zoom command transmitter with inter-command gap
module visca_zoom_tx
  import visca_pkg::*;
#(
  parameter int CAM_ADDR   = 1,
  parameter int GAP_CYCLES = 1024,
  parameter int POS_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [2:0]       cmd_speed,
  input  logic [POS_W-1:0] cmd_pos,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic             busy,
  output logic             done
);

  if (CAM_ADDR < 1 || CAM_ADDR > 7) begin : g_bad_addr
    $error("visca_zoom_tx: CAM_ADDR must be 1..7");
  end
  if (POS_W != 16) begin : g_bad_pos
    $error("visca_zoom_tx: POS_W must be 16");
  end

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;

  visca_tx_state_e  state, state_nx;
  logic [3:0]       idx, idx_nx;
  logic [GAP_W-1:0] gap_cnt, gap_nx;
  logic             done_nx;
  logic             live;
  visca_op_e        op_q;
  logic [2:0]       speed_q;
  logic [POS_W-1:0] pos_q;
  logic [7:0]       sel_byte;
  logic             sel_last;
  logic             accept;

  // live keeps cmd_ready low until the first clock after reset release
  assign accept    = cmd_valid && cmd_ready;
  assign cmd_ready = live && (state == ST_IDLE);
  assign tx_valid  = (state == ST_SEND);
  assign tx_data   = tx_valid ? sel_byte : 8'h00;
  assign busy      = (state != ST_IDLE);

  visca_zoom_bytesel #(.CAM_ADDR(CAM_ADDR)) u_bytesel (
    .op    (op_q),
    .index (idx),
    .speed (speed_q),
    .pos   (pos_q[15:0]),
    .data  (sel_byte),
    .last  (sel_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      idx     <= 4'd0;
      gap_cnt <= '0;
      done    <= 1'b0;
      live    <= 1'b0;
      op_q    <= VISCA_OP_STOP;
      speed_q <= 3'd0;
      pos_q   <= '0;
    end else begin
      state   <= state_nx;
      idx     <= idx_nx;
      gap_cnt <= gap_nx;
      done    <= done_nx;
      live    <= 1'b1;
      if (accept) begin
        op_q    <= visca_op_e'(cmd_op);
        speed_q <= cmd_speed;
        pos_q   <= cmd_pos;
      end
    end
  end

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    gap_nx   = gap_cnt;
    done_nx  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_nx = ST_SEND;
          idx_nx   = 4'd0;
        end
      end
      ST_SEND: begin
        if (tx_ready) begin
          if (sel_last) begin
            done_nx = 1'b1;
            idx_nx  = 4'd0;
            if (GAP_CYCLES == 0) begin
              state_nx = ST_IDLE;
            end else begin
              state_nx = ST_GAP;
              gap_nx   = GAP_LOAD;
            end
          end else begin
            idx_nx = idx + 4'd1;
          end
        end
      end
      ST_GAP: begin
        // the zero count still occupies one cycle, giving exactly GAP_CYCLES
        if (gap_cnt == '0) state_nx = ST_IDLE;
        else               gap_nx   = gap_cnt - 1'b1;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_visca_zoom_tx.sv
// tb/tb_visca_zoom_tx.sv - self-checking bench for visca_zoom_tx
module tb_visca_zoom_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        tx_ready = 1'b0;
  logic [1:0]  cmd_op = 2'd0;
  logic [2:0]  cmd_speed = 3'd0;
  logic [15:0] cmd_pos = 16'd0;

  logic       a_cmd_ready, a_tx_valid, a_busy, a_done;
  logic [7:0] a_tx_data;
  logic       b_cmd_ready, b_tx_valid, b_busy, b_done;
  logic [7:0] b_tx_data;

  logic       o_ready, o_tx_valid, o_busy, o_done;
  logic [7:0] o_tx_data;

  int tests = 0;
  int fails = 0;
  logic [7:0] exp_q[$];
  int pend_op, pend_spd, pend_pos;

  always #5 clk = ~clk;

  visca_zoom_tx #(.CAM_ADDR(1), .GAP_CYCLES(4), .POS_W(16)) dut_a (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid && !sel),
    .cmd_ready (a_cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_speed (cmd_speed),
    .cmd_pos   (cmd_pos),
    .tx_data   (a_tx_data),
    .tx_valid  (a_tx_valid),
    .tx_ready  (tx_ready && !sel),
    .busy      (a_busy),
    .done      (a_done)
  );

  visca_zoom_tx #(.CAM_ADDR(2), .GAP_CYCLES(0), .POS_W(16)) dut_b (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid && sel),
    .cmd_ready (b_cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_speed (cmd_speed),
    .cmd_pos   (cmd_pos),
    .tx_data   (b_tx_data),
    .tx_valid  (b_tx_valid),
    .tx_ready  (tx_ready && sel),
    .busy      (b_busy),
    .done      (b_done)
  );

  assign o_ready    = sel ? b_cmd_ready : a_cmd_ready;
  assign o_tx_valid = sel ? b_tx_valid  : a_tx_valid;
  assign o_tx_data  = sel ? b_tx_data   : a_tx_data;
  assign o_busy     = sel ? b_busy      : a_busy;
  assign o_done     = sel ? b_done      : a_done;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference packet built straight from the VISCA byte layout
  function automatic void build_pkt(input int op, input int spd, input int pos, input int cam);
    exp_q.delete();
    exp_q.push_back(8'(128 + cam));
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h04);
    if (op == 3) begin
      exp_q.push_back(8'h47);
      for (int i = 0; i < 4; i++) exp_q.push_back(8'((pos >> (12 - 4 * i)) % 16));
    end else begin
      exp_q.push_back(8'h07);
      if (op == 0)      exp_q.push_back(8'h00);
      else if (op == 1) exp_q.push_back(8'(32 + spd));
      else              exp_q.push_back(8'(48 + spd));
    end
    exp_q.push_back(8'hFF);
  endfunction

  task automatic run_pkt(input int op, input int spd, input int pos, input int mode, input bit hold);
    int gap, k, n, cyc, phase;
    logic rdy;
    gap = sel ? 0 : 4;
    build_pkt(op, spd, pos, sel ? 2 : 1);
    cmd_op = 2'(op); cmd_speed = 3'(spd); cmd_pos = 16'(pos);
    cmd_valid = 1'b1;
    tx_ready = 1'b0;
    n = 0;
    while (!o_ready && n < 100) begin @(negedge clk); n++; end
    check("req_ready", 32'(o_ready), 32'd1);
    @(negedge clk);
    if (hold) begin
      pend_op  = $urandom_range(0, 3);
      pend_spd = $urandom_range(0, 7);
      pend_pos = $urandom_range(0, 65535);
      cmd_op = 2'(pend_op); cmd_speed = 3'(pend_spd); cmd_pos = 16'(pend_pos);
    end else begin
      cmd_valid = 1'b0;
    end
    k = 0; cyc = 0; phase = 0;
    while (k < exp_q.size() && cyc < 300) begin
      check("tx_valid", 32'(o_tx_valid), 32'd1);
      check("tx_byte", 32'(o_tx_data), 32'(exp_q[k]));
      check("no_accept", 32'(o_ready), 32'd0);
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (phase % 4 == 0) || (phase % 4 == 3);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      phase++;
      tx_ready = rdy;
      if (rdy) k++;
      @(negedge clk);
      cyc++;
    end
    tx_ready = 1'b0;
    check("bytes_sent", 32'(k), 32'(exp_q.size()));
    check("done_pulse", 32'(o_done), 32'd1);
    check("valid_after", 32'(o_tx_valid), 32'd0);
    check("data_idle", 32'(o_tx_data), 32'd0);
    check("busy_gap", 32'(o_busy), 32'(gap > 0));
    n = 0;
    while (!o_ready && n < 100) begin
      @(negedge clk);
      n++;
      check("gap_quiet", {30'd0, o_done, o_tx_valid}, 32'd0);
    end
    check("gap_len", 32'(n), 32'(gap));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(o_ready), 32'd0);
    check("rst_valid", 32'(o_tx_valid), 32'd0);
    check("rst_data", 32'(o_tx_data), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_done", 32'(o_done), 32'd0);
    rst = 1'b0;
    check("ready_at_release", 32'(o_ready), 32'd0);
    @(negedge clk);
    check("ready_after_release", 32'(o_ready), 32'd1);

    run_pkt(0, 0, 0, 0, 1'b0);
    run_pkt(2, 7, 0, 1, 1'b0);
    run_pkt(3, 0, 16'h1A2B, 0, 1'b0);

    sel = 1'b1;
    run_pkt(1, 5, 0, 0, 1'b0);
    for (int i = 0; i < 4; i++)
      run_pkt($urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 65535), 2, 1'b0);
    run_pkt(1, 3, 0, 0, 1'b1);
    run_pkt(pend_op, pend_spd, pend_pos, 0, 1'b0);

    sel = 1'b0;
    run_pkt(2, 4, 0, 0, 1'b1);
    run_pkt(pend_op, pend_spd, pend_pos, 2, 1'b0);
    for (int i = 0; i < 6; i++)
      run_pkt($urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 65535),
              $urandom_range(0, 2), 1'b0);

    // Reset in the middle of a direct packet
    build_pkt(3, 0, 16'hC3D5, 1);
    cmd_op = 2'd3; cmd_speed = 3'd0; cmd_pos = 16'hC3D5; cmd_valid = 1'b1;
    for (int n = 0; n < 100 && !o_ready; n++) @(negedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    tx_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("pre_rst_byte", 32'(o_tx_data), 32'(exp_q[3]));
    tx_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("midrst_valid", 32'(o_tx_valid), 32'd0);
    check("midrst_busy", 32'(o_busy), 32'd0);
    check("midrst_data", 32'(o_tx_data), 32'd0);
    check("midrst_ready", 32'(o_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_midrst", 32'(o_ready), 32'd1);
    run_pkt(0, 0, 0, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
